// File: rtl/axi_stream_transmitter.sv
// axi_stream_transmitter
// Master end of the SHA3 AXI-Stream link. A whole digest (up to 64 bytes) is
// taken in one parallel handshake and sent as DATA_WIDTH-bit beats, byte 0
// first. Every output is a register, so TVALID never depends combinationally
// on TREADY, and all beat fields hold steady while a beat is stalled.
module axi_stream_transmitter #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [511:0]            in_data,
   input  logic [1:0]              in_type,
   input  logic [7:0]              in_dest,
   input  logic                    in_id,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [DATA_WIDTH-1:0]   TDATA,
   output logic                    TVALID,
   input  logic                    TREADY,
   output logic                    TLAST,
   output logic [DATA_WIDTH/8-1:0] TKEEP,
   output logic [DATA_WIDTH/8-1:0] TSTRB,
   output logic                    TID,
   output logic [7:0]              TDEST,
   output logic [1:0]              TUSER
);

   // Bytes carried per beat; the beat counter reaches at most 63 (64 beats of 8 bits)
   localparam int KW = DATA_WIDTH / 8;
   localparam int CW = 7;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Digest length in bytes for each SHA3 variant
   function automatic logic [6:0] digest_bytes(input logic [1:0] t);
      logic [6:0] n;
      case (t)
         2'd0:    n = 7'd28;
         2'd1:    n = 7'd32;
         2'd2:    n = 7'd48;
         2'd3:    n = 7'd64;
         default: n = 7'd64;
      endcase
      return n;
   endfunction

   // Beats needed for a variant: bytes rounded up to whole beats, never zero
   function automatic logic [CW-1:0] beat_count(input logic [1:0] t);
      int nb;
      nb = (int'(digest_bytes(t)) + KW - 1) / KW;
      return CW'(nb);
   endfunction

   // Byte-valid mask: full on every beat except a short final beat
   function automatic logic [KW-1:0] beat_keep(input logic [1:0] t, input logic last);
      logic [KW-1:0] k;
      int rem;
      rem = int'(digest_bytes(t)) % KW;
      for (int i = 0; i < KW; i++) begin
         if (!last || (rem == 0) || (i < rem)) begin
            k[i] = 1'b1;
         end else begin
            k[i] = 1'b0;
         end
      end
      return k;
   endfunction

   // Drive unkept bytes to zero so no stale digest bytes leak onto the bus
   function automatic logic [DATA_WIDTH-1:0] mask_bytes(input logic [DATA_WIDTH-1:0] d,
                                                        input logic [KW-1:0] k);
      logic [DATA_WIDTH-1:0] m;
      for (int i = 0; i < KW; i++) begin
         if (k[i]) begin
            m[8*i +: 8] = d[8*i +: 8];
         end else begin
            m[8*i +: 8] = 8'h00;
         end
      end
      return m;
   endfunction

   state_t                state_q;
   logic [511:0]          shift_q;
   logic [CW-1:0]         cnt_q;
   logic                  in_ready_q;
   logic                  tvalid_q;
   logic                  tlast_q;
   logic [DATA_WIDTH-1:0] tdata_q;
   logic [KW-1:0]         tkeep_q;
   logic                  tid_q;
   logic [7:0]            tdest_q;
   logic [1:0]            tuser_q;

   logic [511:0]          shift_d;
   logic [CW-1:0]         cnt_d;
   logic                  last_d;
   logic [KW-1:0]         keep_d;
   logic [DATA_WIDTH-1:0] data_d;
   logic [CW-1:0]         nb_last_s;
   logic                  first_last_s;
   logic [KW-1:0]         first_keep_s;
   logic [DATA_WIDTH-1:0] first_data_s;

   // Index of the final beat for the digest being sent (TUSER holds its type)
   assign nb_last_s = beat_count(tuser_q) - 7'd1;

   // Fields of the beat that follows a non-final handshake
   always_comb begin
      shift_d = shift_q >> DATA_WIDTH;
      cnt_d   = cnt_q + 7'd1;
      last_d  = (cnt_d == nb_last_s);
      keep_d  = beat_keep(tuser_q, last_d);
      data_d  = mask_bytes(shift_d[DATA_WIDTH-1:0], keep_d);
   end

   // Fields of the first beat, taken straight from the offered digest
   always_comb begin
      first_last_s = (beat_count(in_type) == 7'd1);
      first_keep_s = beat_keep(in_type, first_last_s);
      first_data_s = mask_bytes(in_data[DATA_WIDTH-1:0], first_keep_s);
   end

   // Control FSM: accept a digest in IDLE, emit one beat per handshake in SEND
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         in_ready_q <= 1'b0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         tdata_q    <= '0;
         tkeep_q    <= '0;
         tid_q      <= 1'b0;
         tdest_q    <= 8'h00;
         tuser_q    <= 2'b00;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  shift_q    <= in_data;
                  cnt_q      <= '0;
                  tuser_q    <= in_type;
                  tdest_q    <= in_dest;
                  tid_q      <= in_id;
                  tdata_q    <= first_data_s;
                  tkeep_q    <= first_keep_s;
                  tlast_q    <= first_last_s;
                  tvalid_q   <= 1'b1;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_SEND;
               end else begin
                  // ready rises on the first edge out of reset and stays up while idle
                  in_ready_q <= 1'b1;
               end
            end
            ST_SEND: begin
               if (tvalid_q && TREADY) begin
                  if (tlast_q) begin
                     tvalid_q   <= 1'b0;
                     tlast_q    <= 1'b0;
                     cnt_q      <= '0;
                     in_ready_q <= 1'b1;
                     state_q    <= ST_IDLE;
                  end else begin
                     shift_q <= shift_d;
                     cnt_q   <= cnt_d;
                     tdata_q <= data_d;
                     tkeep_q <= keep_d;
                     tlast_q <= last_d;
                  end
               end else begin
                  // stalled: every beat field holds until the sink takes it
                  tvalid_q <= tvalid_q;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               tvalid_q   <= 1'b0;
               tlast_q    <= 1'b0;
               cnt_q      <= '0;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = in_ready_q;
   assign TVALID   = tvalid_q;
   assign TLAST    = tlast_q;
   assign TDATA    = tdata_q;
   assign TKEEP    = tkeep_q;
   assign TSTRB    = tkeep_q;
   assign TID      = tid_q;
   assign TDEST    = tdest_q;
   assign TUSER    = tuser_q;

endmodule

// File: tb/tb_axi_stream_transmitter.sv
// Bench for axi_stream_transmitter: three instances (16/64/512-bit beats)
// share the digest inputs; sel picks which one is offered a digest and observed.
// Expected beats come from a byte-stream model of the digest.
module tb_axi_stream_transmitter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [511:0] in_data;
   logic [1:0]   in_type;
   logic [7:0]   in_dest;
   logic         in_id;
   logic         in_valid;
   logic         tready;
   int           sel;
   int           errors;
   int           checks;

   logic v16, v64, v512;
   assign v16  = in_valid && (sel == 16);
   assign v64  = in_valid && (sel == 64);
   assign v512 = in_valid && (sel == 512);

   logic [15:0]  tdata16;  logic [1:0]  tkeep16, tstrb16;
   logic [63:0]  tdata64;  logic [7:0]  tkeep64, tstrb64;
   logic [511:0] tdata512; logic [63:0] tkeep512, tstrb512;
   logic tvalid16, tlast16, tid16, rdy16;
   logic tvalid64, tlast64, tid64, rdy64;
   logic tvalid512, tlast512, tid512, rdy512;
   logic [7:0] tdest16, tdest64, tdest512;
   logic [1:0] tuser16, tuser64, tuser512;

   axi_stream_transmitter #(.DATA_WIDTH(16)) u16 (
      .ACLK(clk), .ARESET(rst), .in_data(in_data), .in_type(in_type), .in_dest(in_dest),
      .in_id(in_id), .in_valid(v16), .in_ready(rdy16), .TDATA(tdata16), .TVALID(tvalid16),
      .TREADY(tready), .TLAST(tlast16), .TKEEP(tkeep16), .TSTRB(tstrb16), .TID(tid16),
      .TDEST(tdest16), .TUSER(tuser16));

   axi_stream_transmitter #(.DATA_WIDTH(64)) u64 (
      .ACLK(clk), .ARESET(rst), .in_data(in_data), .in_type(in_type), .in_dest(in_dest),
      .in_id(in_id), .in_valid(v64), .in_ready(rdy64), .TDATA(tdata64), .TVALID(tvalid64),
      .TREADY(tready), .TLAST(tlast64), .TKEEP(tkeep64), .TSTRB(tstrb64), .TID(tid64),
      .TDEST(tdest64), .TUSER(tuser64));

   axi_stream_transmitter #(.DATA_WIDTH(512)) u512 (
      .ACLK(clk), .ARESET(rst), .in_data(in_data), .in_type(in_type), .in_dest(in_dest),
      .in_id(in_id), .in_valid(v512), .in_ready(rdy512), .TDATA(tdata512), .TVALID(tvalid512),
      .TREADY(tready), .TLAST(tlast512), .TKEEP(tkeep512), .TSTRB(tstrb512), .TID(tid512),
      .TDEST(tdest512), .TUSER(tuser512));

   logic [511:0] o_tdata;
   logic [63:0]  o_tkeep, o_tstrb;
   logic         o_tvalid, o_tlast, o_tid, o_rdy;
   logic [7:0]   o_tdest;
   logic [1:0]   o_tuser;

   // Route the selected instance onto one zero-extended observation bus
   always_comb begin
      o_tdata = '0; o_tkeep = '0; o_tstrb = '0;
      o_tvalid = 1'b0; o_tlast = 1'b0; o_tid = 1'b0; o_rdy = 1'b0;
      o_tdest = 8'h00; o_tuser = 2'b00;
      case (sel)
         16: begin
            o_tdata[15:0] = tdata16; o_tkeep[1:0] = tkeep16; o_tstrb[1:0] = tstrb16;
            o_tvalid = tvalid16; o_tlast = tlast16; o_tid = tid16; o_rdy = rdy16;
            o_tdest = tdest16; o_tuser = tuser16;
         end
         64: begin
            o_tdata[63:0] = tdata64; o_tkeep[7:0] = tkeep64; o_tstrb[7:0] = tstrb64;
            o_tvalid = tvalid64; o_tlast = tlast64; o_tid = tid64; o_rdy = rdy64;
            o_tdest = tdest64; o_tuser = tuser64;
         end
         512: begin
            o_tdata = tdata512; o_tkeep = tkeep512; o_tstrb = tstrb512;
            o_tvalid = tvalid512; o_tlast = tlast512; o_tid = tid512; o_rdy = rdy512;
            o_tdest = tdest512; o_tuser = tuser512;
         end
         default: ;
      endcase
   end

   // ---------------- reference model: digest as a byte stream ----------------
   function automatic int m_bytes(input logic [1:0] t);
      int tbl[4] = '{28, 32, 48, 64};
      return tbl[t];
   endfunction

   function automatic int m_nbeats(input logic [1:0] t, input int w);
      return (m_bytes(t) * 8 + w - 1) / w;
   endfunction

   function automatic logic [511:0] m_data(input logic [511:0] d, input logic [1:0] t,
                                           input int w, input int b);
      logic [511:0] r = '0;
      for (int j = 0; j < w / 8; j++) begin
         int k = b * (w / 8) + j;
         if (k < m_bytes(t)) r[8*j +: 8] = d[8*k +: 8];
      end
      return r;
   endfunction

   function automatic logic [63:0] m_keep(input logic [1:0] t, input int w, input int b);
      logic [63:0] r = '0;
      for (int j = 0; j < w / 8; j++) begin
         if (b * (w / 8) + j < m_bytes(t)) r[j] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   // Offer a digest, wait for acceptance, then scramble the inputs
   task automatic offer(input int w, input logic [1:0] t, input logic [511:0] d,
                        input logic [7:0] dest, input logic id);
      int n = 0;
      sel = w; in_type = t; in_data = d; in_dest = dest; in_id = id; in_valid = 1'b1;
      #1;
      while (!o_rdy && n < 100) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (!o_rdy) begin
         errors++;
         $display("FAIL offer_wait: in_ready=%0b required 1", o_rdy);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data = rand512(); in_type = 2'($urandom); in_dest = 8'($urandom); in_id = 1'($urandom);
   endtask

   task automatic test_reset();
      @(negedge clk);
      foreach (sel_list[i]) begin
         sel = sel_list[i]; #1;
         checks++;
         if ({o_rdy, o_tvalid, o_tlast, o_tdata, o_tkeep, o_tstrb, o_tuser, o_tdest, o_tid} !== '0) begin
            errors++;
            $display("FAIL reset_state w=%0d: rdy=%0b v=%0b l=%0b k=%h d=%h user=%0d dest=%h id=%0b required all 0",
                     sel, o_rdy, o_tvalid, o_tlast, o_tkeep, o_tdata, o_tuser, o_tdest, o_tid);
         end
      end
      sel = 16;
      @(negedge clk); rst = 1'b0; #1;
      checks++;
      if (o_rdy !== 1'b0) begin errors++; $display("FAIL ready_before_edge: in_ready=%0b required 0", o_rdy); end
      @(negedge clk);
      checks++;
      if (o_rdy !== 1'b1) begin errors++; $display("FAIL ready_after_edge: in_ready=%0b required 1", o_rdy); end
   endtask

   int sel_list[3] = '{16, 64, 512};

   // 256-bit digest at 16-bit beats, byte k holds k, sink always ready
   task automatic test_narrow_256();
      logic [511:0] d; logic [1:0] t = 2'd1; logic [7:0] dest = 8'h3C; logic id = 1'b1;
      int nb, b = 0, cyc = 0;
      for (int k = 0; k < 64; k++) d[8*k +: 8] = 8'(k);
      nb = m_nbeats(t, 16);
      tready = 1'b1;
      offer(16, t, d, dest, id);
      while (b < nb && cyc < 200) begin
         checks++;
         if ({o_tvalid, o_tlast, o_tkeep, o_tstrb, o_tdata, o_tuser, o_tdest, o_tid} !==
             {1'b1, (b == nb - 1), m_keep(t, 16, b), m_keep(t, 16, b), m_data(d, t, 16, b), t, dest, id}) begin
            errors++;
            $display("FAIL narrow256 beat %0d: got v=%0b l=%0b k=%h d=%h required l=%0b k=%h d=%h",
                     b, o_tvalid, o_tlast, o_tkeep, o_tdata[15:0], (b == nb - 1), m_keep(t, 16, b), m_data(d, t, 16, b));
         end
         b++;
         @(negedge clk); cyc++;
      end
      checks++;
      if (cyc != nb || o_tvalid !== 1'b0 || o_rdy !== 1'b1) begin
         errors++;
         $display("FAIL narrow256_end: cycles=%0d v=%0b rdy=%0b required cycles=%0d v=0 rdy=1", cyc, o_tvalid, o_rdy, nb);
      end
   endtask

   // 224-bit digest at 64-bit beats: short final beat with zeroed upper bytes
   task automatic test_partial_224();
      logic [511:0] d = rand512(); logic [1:0] t = 2'd0; logic [7:0] dest = 8'($urandom); logic id = 1'b0;
      int nb, b = 0, cyc = 0;
      nb = m_nbeats(t, 64);
      tready = 1'b1;
      offer(64, t, d, dest, id);
      while (b < nb && cyc < 50) begin
         checks++;
         if ({o_tvalid, o_tlast, o_tkeep, o_tstrb, o_tdata, o_tuser, o_tdest, o_tid} !==
             {1'b1, (b == nb - 1), m_keep(t, 64, b), m_keep(t, 64, b), m_data(d, t, 64, b), t, dest, id}) begin
            errors++;
            $display("FAIL partial224 beat %0d: got l=%0b k=%h d=%h required l=%0b k=%h d=%h",
                     b, o_tlast, o_tkeep, o_tdata[63:0], (b == nb - 1), m_keep(t, 64, b), m_data(d, t, 64, b));
         end
         b++;
         @(negedge clk); cyc++;
      end
      checks++;
      if (cyc != 4 || o_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL partial224_count: beats=%0d v=%0b required beats=4 v=0", cyc, o_tvalid);
      end
   endtask

   // 512-bit digest at 16-bit beats, sink stalls three cycles on the second beat
   task automatic test_backpressure();
      logic [511:0] d = rand512(); logic [1:0] t = 2'd3; logic [7:0] dest = 8'($urandom); logic id = 1'($urandom);
      int nb, b = 0, cyc = 0, stall = 0;
      nb = m_nbeats(t, 16);
      tready = 1'b1;
      offer(16, t, d, dest, id);
      while (b < nb && cyc < 200) begin
         tready = !(b == 1 && stall < 3);
         if (!tready) stall++;
         checks++;
         if ({o_tvalid, o_tlast, o_tkeep, o_tstrb, o_tdata, o_tuser, o_tdest, o_tid} !==
             {1'b1, (b == nb - 1), m_keep(t, 16, b), m_keep(t, 16, b), m_data(d, t, 16, b), t, dest, id}) begin
            errors++;
            $display("FAIL backpressure beat %0d stall %0d: got v=%0b l=%0b k=%h d=%h required l=%0b k=%h d=%h",
                     b, stall, o_tvalid, o_tlast, o_tkeep, o_tdata[15:0], (b == nb - 1), m_keep(t, 16, b), m_data(d, t, 16, b));
         end
         if (tready) b++;
         @(negedge clk); cyc++;
      end
      tready = 1'b1;
      checks++;
      if (b != 32 || cyc != 35 || o_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_count: beats=%0d cycles=%0d v=%0b required beats=32 cycles=35 v=0", b, cyc, o_tvalid);
      end
   endtask

   // in_valid held high across two digests: exactly one idle cycle between packets
   task automatic test_back_to_back();
      logic [511:0] d1 = rand512(), d2 = rand512();
      logic [1:0] t1 = 2'd2, t2 = 2'd3;
      logic id1 = 1'b0, id2 = 1'b1;
      int n = 0, b, cyc;
      tready = 1'b1;
      sel = 16; in_type = t1; in_data = d1; in_dest = 8'hA5; in_id = id1; in_valid = 1'b1;
      #1;
      while (!o_rdy && n < 100) begin @(negedge clk); #1; n++; end
      @(negedge clk);
      in_type = t2; in_data = d2; in_dest = 8'h5A; in_id = id2;
      for (int p = 0; p < 2; p++) begin
         logic [511:0] d = (p == 0) ? d1 : d2;
         logic [1:0] t = (p == 0) ? t1 : t2;
         logic [7:0] dest = (p == 0) ? 8'hA5 : 8'h5A;
         logic id = (p == 0) ? id1 : id2;
         int nb = m_nbeats(t, 16);
         b = 0; cyc = 0;
         while (b < nb && cyc < 200) begin
            checks++;
            if ({o_tvalid, o_tlast, o_tkeep, o_tstrb, o_tdata, o_tuser, o_tdest, o_tid} !==
                {1'b1, (b == nb - 1), m_keep(t, 16, b), m_keep(t, 16, b), m_data(d, t, 16, b), t, dest, id}) begin
               errors++;
               $display("FAIL b2b pkt %0d beat %0d: got v=%0b l=%0b k=%h d=%h user=%0d dest=%h id=%0b required l=%0b d=%h user=%0d dest=%h id=%0b",
                        p, b, o_tvalid, o_tlast, o_tkeep, o_tdata[15:0], o_tuser, o_tdest, o_tid,
                        (b == nb - 1), m_data(d, t, 16, b), t, dest, id);
            end
            b++;
            @(negedge clk); cyc++;
            if (b == 1) in_valid = (p == 0);
         end
         checks++;
         if (o_tvalid !== 1'b0 || o_rdy !== 1'b1 || b != nb) begin
            errors++;
            $display("FAIL b2b_gap pkt %0d: beats=%0d v=%0b rdy=%0b required beats=%0d v=0 rdy=1", p, b, o_tvalid, o_rdy, nb);
         end
         if (p == 0) @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   // Reset during the fifth beat abandons the packet; the next digest goes out whole
   task automatic test_reset_mid();
      logic [511:0] d = rand512(); logic [1:0] t = 2'($urandom); logic [7:0] dest = 8'($urandom); logic id = 1'($urandom);
      int nb, b = 0, cyc = 0;
      tready = 1'b1;
      offer(16, t, d, dest, id);
      while (b < 4 && cyc < 50) begin b++; @(negedge clk); cyc++; end
      #2 rst = 1'b1; #1;
      checks++;
      if (o_tvalid !== 1'b0 || o_rdy !== 1'b0 || o_tlast !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_async: v=%0b rdy=%0b l=%0b required 0 0 0", o_tvalid, o_rdy, o_tlast);
      end
      @(negedge clk); rst = 1'b0; #1;
      checks++;
      if (o_rdy !== 1'b0) begin errors++; $display("FAIL reset_mid_release: in_ready=%0b required 0", o_rdy); end
      @(negedge clk); #1;
      checks++;
      if (o_rdy !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: in_ready=%0b required 1", o_rdy); end
      d = rand512(); t = 2'($urandom); dest = 8'($urandom); id = 1'($urandom);
      nb = m_nbeats(t, 16);
      offer(16, t, d, dest, id);
      b = 0; cyc = 0;
      while (b < nb && cyc < 300) begin
         tready = ($urandom_range(3) != 0);
         checks++;
         if ({o_tvalid, o_tlast, o_tkeep, o_tstrb, o_tdata, o_tuser, o_tdest, o_tid} !==
             {1'b1, (b == nb - 1), m_keep(t, 16, b), m_keep(t, 16, b), m_data(d, t, 16, b), t, dest, id}) begin
            errors++;
            $display("FAIL reset_mid_resend beat %0d: got v=%0b l=%0b d=%h required l=%0b d=%h",
                     b, o_tvalid, o_tlast, o_tdata[15:0], (b == nb - 1), m_data(d, t, 16, b));
         end
         if (tready) b++;
         @(negedge clk); cyc++;
      end
      tready = 1'b1;
      checks++;
      if (b != nb || o_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_resend_end: beats=%0d v=%0b required beats=%0d v=0", b, o_tvalid, nb);
      end
   endtask

   // 512-bit beat: whole digest in one beat, then a 224-bit digest with partial keep
   task automatic test_single_beat();
      for (int p = 0; p < 2; p++) begin
         logic [511:0] d = rand512(); logic [1:0] t = (p == 0) ? 2'd3 : 2'd0;
         logic [7:0] dest = 8'($urandom); logic id = 1'($urandom);
         logic [63:0] ek = (p == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0FFF_FFFF;
         tready = 1'b1;
         offer(512, t, d, dest, id);
         checks++;
         if ({o_tvalid, o_tlast, o_tkeep, o_tstrb, o_tdata, o_tuser, o_tdest, o_tid} !==
             {1'b1, 1'b1, ek, ek, m_data(d, t, 512, 0), t, dest, id}) begin
            errors++;
            $display("FAIL single_beat type %0d: got v=%0b l=%0b k=%h d=%h required l=1 k=%h d=%h",
                     t, o_tvalid, o_tlast, o_tkeep, o_tdata, ek, m_data(d, t, 512, 0));
         end
         @(negedge clk);
         checks++;
         if (o_tvalid !== 1'b0 || o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL single_beat_end type %0d: v=%0b rdy=%0b required v=0 rdy=1", t, o_tvalid, o_rdy);
         end
      end
   endtask

   // Random widths, variants, sidebands and sink stalls
   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         int w = sel_list[$urandom_range(2)];
         logic [511:0] d = rand512(); logic [1:0] t = 2'($urandom);
         logic [7:0] dest = 8'($urandom); logic id = 1'($urandom);
         int nb = m_nbeats(t, w), b = 0, cyc = 0;
         tready = 1'b1;
         offer(w, t, d, dest, id);
         while (b < nb && cyc < 400) begin
            tready = ($urandom_range(3) != 0);
            checks++;
            if ({o_tvalid, o_tlast, o_tkeep, o_tstrb, o_tdata, o_tuser, o_tdest, o_tid} !==
                {1'b1, (b == nb - 1), m_keep(t, w, b), m_keep(t, w, b), m_data(d, t, w, b), t, dest, id}) begin
               errors++;
               $display("FAIL random pkt %0d w=%0d type %0d beat %0d: got v=%0b l=%0b k=%h required l=%0b k=%h",
                        n, w, t, b, o_tvalid, o_tlast, o_tkeep, (b == nb - 1), m_keep(t, w, b));
            end
            if (tready) b++;
            @(negedge clk); cyc++;
         end
         tready = 1'b1;
         checks++;
         if (b != nb || o_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL random_end pkt %0d: beats=%0d v=%0b required beats=%0d v=0", n, b, o_tvalid, nb);
         end
      end
   endtask

   initial begin
      errors = 0; checks = 0; sel = 16;
      in_data = '0; in_type = 2'd0; in_dest = 8'h00; in_id = 1'b0; in_valid = 1'b0; tready = 1'b1;
      rst = 1'b0;
      #2 rst = 1'b1;
      test_reset();
      test_narrow_256();
      test_partial_224();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_single_beat();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
